fifo_rd_stream_adapter: RTL
===========================

Name: fifo_rd_stream_adapter

Overview:
Read-side consumer for async_fifo_wrapper, running in the read clock domain. Drives read_en from rempty and captures rdata, which is valid one cycle after an accepted read. Presents the words as a valid/ready stream through a 2-entry skid buffer. Sustains one word per cycle with no loss, duplication or reordering under arbitrary downstream backpressure.

Parameters:
DATA_LEN, 32, width of FIFO data and stream data
CNT_LEN, 16, width of the optional delivered-word counter

Ports:
rclk  input  1  read-domain clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rclk
enable_i  input  1  permits new FIFO reads when high
rempty_i  input  1  FIFO empty flag (read domain)
rdata_i  input  DATA_LEN  FIFO read data, valid one cycle after an accepted read
read_en_o  output  1  FIFO read request
m_data_o  output  DATA_LEN  stream data
m_valid_o  output  1  stream data valid
m_ready_i  input  1  downstream accepts m_data_o
rd_count_o  output  CNT_LEN  delivered-word count (only with FIFO_RD_CNT_EN)

Behaviour:
- Clock and reset: single clock rclk. rst_n is synchronous, active-low, sampled on the rclk rising edge only.
- Reset (rst_n=0 at an rclk edge):
  - occ=0, inflight=0, head=0, tail=0.
  - m_valid_o=0, m_data_o=0.
  - read_en_o is forced to 0 combinationally while rst_n=0.
- State:
  - occ: buffer occupancy, 0..2.
  - inflight: 1 bit; registered copy of read_en_o.
  - head and tail: DATA_LEN registers. head always holds the oldest word.
- Stream outputs: m_valid_o = (occ!=0); m_data_o = head.
- pop = m_valid_o && m_ready_i.
- Read request: read_en_o = rst_n && enable_i && !rempty_i && ((occ + inflight - pop) < 2).
  - This is combinational from m_ready_i, which is required for full throughput.
  - Invariant: occ + inflight <= 2 at all times.
- Capture: when inflight=1, rdata_i is pushed in the same cycle (push=1).
- Buffer update per edge:
  - occ=0, push: head<=rdata_i, occ<=1.
  - occ=1, push, no pop: tail<=rdata_i, occ<=2.
  - occ=1, push and pop: head<=rdata_i, occ stays 1.
  - occ=1, pop only: occ<=0; head keeps its value.
  - occ=2, pop (push impossible by credit rule): head<=tail, occ<=1.
  - occ=2, push without pop: illegal. Simulation assertion must fire.
- Handshake rules:
  - m_data_o holds stable while m_valid_o && !m_ready_i.
  - m_valid_o never drops without a pop.
- Latency:
  - First word: rempty_i falls at cycle N, read_en_o is high at N, m_valid_o is high at N+2.
  - Steady state with m_ready_i=1: one word per cycle.
- enable_i low: no new reads are issued. A word already in flight is still captured. The buffer continues to drain.
- rempty_i high: read_en_o=0. An in-flight word is still captured.
- Reset mid-operation: buffered and in-flight words are discarded. An in-flight rdata_i arriving during the reset cycle is ignored.

Optional Feature:
Macro FIFO_RD_CNT_EN.
- Defined:
  - rd_count_o increments by 1 on each pop and wraps from 2^CNT_LEN-1 to 0.
  - It resets to 0 and is reset-controlled like the other state.
- Not defined: the rd_count_o port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then FIFO preloaded with 0x11111111, 0x22222222, 0x33333333, m_ready_i=1, enable_i=1 -> read_en_o high 3 consecutive cycles; m_valid_o from 2 cycles after the first read; words delivered in order on consecutive cycles; afterwards m_valid_o=0, read_en_o=0.
2. FIFO holds 8 words, m_ready_i=0 -> exactly 2 reads issued; occ=2; m_data_o is the first word and stays stable. Then m_ready_i=1 -> all 8 words delivered in order with no gap beyond the initial refill.
3. m_ready_i toggles on a 1-on/1-off pattern over 1000 $random words written from wclk (async to rclk) -> scoreboard matches the full sequence: no drops, no duplicates, assertion never fires.
4. enable_i driven low while a read is in flight with word 0xDEADBEEF -> 0xDEADBEEF is still delivered; no further read_en_o until enable_i=1.
5. rst_n=0 for one cycle with occ=2 and inflight=1 -> next cycle m_valid_o=0 and read_en_o=0; the first word delivered after reset is the next unread FIFO word.
6. With FIFO_RD_CNT_EN defined and CNT_LEN=4, deliver 18 words -> rd_count_o=2, having wrapped once at 16.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
//
// Read-side consumer for async_fifo_wrapper, in the read clock domain. It issues FIFO reads
// whenever the 2-entry skid buffer has a free slot for the data, captures rdata one cycle
// after each accepted read, and presents the words on a valid/ready stream. It sustains one
// word per cycle under arbitrary backpressure without loss, duplication or reordering.
//
// Optional build macro: FIFO_RD_CNT_EN adds rd_count_o, a wrapping count of delivered words.
//
// Ports:
//   rclk        read-domain clock, rising edge
//   rst_n       synchronous active-low reset
//   enable_i    permits new FIFO reads
//   rempty_i    FIFO empty flag
//   rdata_i     FIFO read data, valid one cycle after an accepted read
//   read_en_o   FIFO read request
//   m_data_o    stream data (oldest buffered word)
//   rd_count_o  delivered-word count (FIFO_RD_CNT_EN builds only)
//   m_valid_o   stream data valid
//   m_ready_i   downstream accepts m_data_o

module fifo_rd_stream_adapter #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned CNT_LEN  = 16
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic                rempty_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  output logic                read_en_o,
  output logic [DATA_LEN-1:0] m_data_o,
`ifdef FIFO_RD_CNT_EN
  output logic [CNT_LEN-1:0]  rd_count_o,
`endif
  output logic                m_valid_o,
  input  logic                m_ready_i
);

  if (DATA_LEN == 0 || CNT_LEN == 0) begin : g_bad_param
    $error("fifo_rd_stream_adapter: DATA_LEN and CNT_LEN must be non-zero");
  end

  logic [1:0]          occ_q, occ_d;
  logic                inflight_q;
  logic [DATA_LEN-1:0] head_q, head_d;
  logic [DATA_LEN-1:0] tail_q, tail_d;

  logic       push;
  logic       pop;
  logic [2:0] level;

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = head_q;
  assign pop       = m_valid_o && m_ready_i;
  assign push      = inflight_q;

  // Slots committed after this edge: buffered + in flight - leaving now. Pop never exceeds
  // occ, so no underflow. Depending on pop combinationally lets a full buffer keep reading
  // while it drains, which is what gives one word per cycle.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    read_en_o = rst_n && enable_i && !rempty_i && (level < 3'd2);
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = rdata_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && !pop) begin
          tail_d = rdata_i;
          occ_d  = 2'd2;
        end else if (push && pop) begin
          head_d = rdata_i;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      2'd2: begin
        // The credit rule keeps inflight low here, so only a pop can happen.
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= read_en_o;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_LEN-1:0] cnt_q;

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_LEN'(1);
    end
  end

  assign rd_count_o = cnt_q;
`else
  // No delivered-word counter in this build.
`endif

  a_no_push_when_full: assert property (@(posedge rclk) disable iff (!rst_n)
    !(occ_q == 2'd2 && push && !pop))
    else $error("push into full skid buffer");

  a_credit: assert property (@(posedge rclk) disable iff (!rst_n)
    ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2)
    else $error("skid buffer credit overrun");

endmodule
